calc_entry_fsm: RTL and testbench



---
 rtl/calc_entry_fsm.sv | 120 ++++++++++++
 tb/tb_calc_entry_fsm.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/calc_entry_fsm.sv
// Purpose: operand/operation entry sequencer for the four-function calculator; captures the ALU result (optional CALC_DIV_EN adds divide mode and a divide-by-zero guard).
// Latency: an accepted enter updates its register and phase after that edge; the result is captured one SETTLE cycle after operand b is latched.
// Backpressure: none; an enter in GET_A/GET_OP/GET_B/SHOW is accepted on the same cycle, an enter during SETTLE is dropped, and clear always wins over enter.
module calc_entry_fsm #(
    parameter int DATA_W = 4,
    parameter int RES_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sw,
    input  logic              enter,
    input  logic              clear,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_mode,
    input  logic [RES_W-1:0]  alu_out,
    input  logic              alu_neg,
    output logic [RES_W-1:0]  result,
    output logic              result_neg,
    output logic              result_valid,
    output logic              err,
    output logic [2:0]        phase
);

    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_OP = 3'd1,
        GET_B  = 3'd2,
        SETTLE = 3'd3,
        SHOW   = 3'd4
    } state_t;

    state_t state;

    // The display indicators see the state register directly.
    assign phase = state;

    // Mode codes the ALU understands in this build.
    function automatic logic op_ok(input logic [DATA_W-1:0] code);
        logic ok;
        ok = (code == DATA_W'(1)) || (code == DATA_W'(2)) || (code == DATA_W'(3));
`ifdef CALC_DIV_EN
        ok = ok || (code == DATA_W'(4));
`endif
        return ok;
    endfunction

    // Entry sequencing, result capture and error flag, all in one registered process.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            alu_a        <= '0;
            alu_b        <= '0;
            alu_mode     <= '0;
            result       <= '0;
            result_neg   <= 1'b0;
            result_valid <= 1'b0;
            err          <= 1'b0;
            state        <= GET_A;
        end else begin
            case (state)
                GET_A: begin
                    if (enter) begin
                        alu_a <= sw;
                        err   <= 1'b0;
                        state <= GET_OP;
                    end
                end
                GET_OP: begin
                    if (enter) begin
                        if (op_ok(sw)) begin
                            alu_mode <= 4'(sw);
                            err      <= 1'b0;
                            state    <= GET_B;
                        end else begin
                            // Unknown code: keep the old mode and wait for a valid one.
                            err <= 1'b1;
                        end
                    end
                end
                GET_B: begin
                    if (enter) begin
`ifdef CALC_DIV_EN
                        if ((alu_mode == 4'd4) && (sw == '0)) begin
                            // Divisor of zero is refused; operand b stays as it was.
                            err <= 1'b1;
                        end else begin
                            alu_b <= sw;
                            err   <= 1'b0;
                            state <= SETTLE;
                        end
`else
                        alu_b <= sw;
                        err   <= 1'b0;
                        state <= SETTLE;
`endif
                    end
                end
                SETTLE: begin
                    // ALU has had a full cycle with the final operands; take its answer.
                    result       <= alu_out;
                    result_neg   <= alu_neg;
                    result_valid <= 1'b1;
                    state        <= SHOW;
                end
                SHOW: begin
                    if (enter) begin
                        // New calculation chained off the switch value; old result stays visible but invalid.
                        alu_a        <= sw;
                        result_valid <= 1'b0;
                        state        <= GET_OP;
                    end
                end
                default: begin
                    state <= GET_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_entry_fsm.sv
module tb_calc_entry_fsm;

    logic       clk;
    logic       rst;
    logic [3:0] sw;
    logic       enter;
    logic       clear;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_mode;
    logic [7:0] alu_out;
    logic       alu_neg;
    logic [7:0] result;
    logic       result_neg;
    logic       result_valid;
    logic       err;
    logic [2:0] phase;

    int nvec = 0;
    int nerr = 0;

    calc_entry_fsm #(.DATA_W(4), .RES_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .sw           (sw),
        .enter        (enter),
        .clear        (clear),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_mode     (alu_mode),
        .alu_out      (alu_out),
        .alu_neg      (alu_neg),
        .result       (result),
        .result_neg   (result_neg),
        .result_valid (result_valid),
        .err          (err),
        .phase        (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in ALU: magnitude plus sign flag.
    always_comb begin
        alu_out = '0;
        alu_neg = 1'b0;
        case (alu_mode)
            4'd1: alu_out = 8'(alu_a) + 8'(alu_b);
            4'd2: begin
                if (alu_a >= alu_b) begin
                    alu_out = 8'(alu_a - alu_b);
                end else begin
                    alu_out = 8'(alu_b - alu_a);
                    alu_neg = 1'b1;
                end
            end
            4'd3: alu_out = 8'(alu_a) * 8'(alu_b);
            4'd4: if (alu_b != 4'd0) alu_out = 8'(alu_a / alu_b);
            default: ;
        endcase
    end

    typedef struct packed {
        logic       rst;
        logic       clr;
        logic       ent;
        logic [3:0] sw;
        logic [2:0] ph;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] m;
        logic       v;
        logic [7:0] r;
        logic       n;
        logic       e;
    } vec_t;

    function automatic vec_t mk(input int r_, input int c_, input int en_, input int s_,
                                input int ph_, input int a_, input int b_, input int m_,
                                input int v_, input int res_, input int n_, input int e_);
        vec_t t;
        t.rst = 1'(r_);  t.clr = 1'(c_);  t.ent = 1'(en_); t.sw = 4'(s_);
        t.ph  = 3'(ph_); t.a   = 4'(a_);  t.b   = 4'(b_);  t.m  = 4'(m_);
        t.v   = 1'(v_);  t.r   = 8'(res_); t.n  = 1'(n_);  t.e  = 1'(e_);
        return t;
    endfunction

    task automatic drive(input logic r_, input logic c_, input logic e_, input logic [3:0] s_);
        @(negedge clk);
        rst   = r_;
        clear = c_;
        enter = e_;
        sw    = s_;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx,
                         input logic [2:0] xph, input logic [3:0] xa, input logic [3:0] xb,
                         input logic [3:0] xm, input logic xv, input logic [7:0] xr,
                         input logic xn, input logic xe);
        nvec++;
        if ({phase, alu_a, alu_b, alu_mode, result_valid, result, result_neg, err} !==
            {xph, xa, xb, xm, xv, xr, xn, xe}) begin
            nerr++;
            $display("FAIL %s[%0d]: got ph=%0d a=%0d b=%0d m=%0d v=%0d r=%0d n=%0d e=%0d, want ph=%0d a=%0d b=%0d m=%0d v=%0d r=%0d n=%0d e=%0d",
                     name, idx, phase, alu_a, alu_b, alu_mode, result_valid, result, result_neg, err,
                     xph, xa, xb, xm, xv, xr, xn, xe);
        end
    endtask

    // Reference model state, expressed as "what the user has entered so far".
    int m_ph, m_a, m_b, m_op, m_res, m_neg, m_vld, m_err;

    function automatic bit mode_legal(input int code);
`ifdef CALC_DIV_EN
        return code >= 1 && code <= 4;
`else
        return code >= 1 && code <= 3;
`endif
    endfunction

    task automatic model_step(input int r_, input int c_, input int e_, input int s_);
        int val;
        if (r_ != 0 || c_ != 0) begin
            m_ph = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_neg = 0; m_vld = 0; m_err = 0;
        end else if (m_ph == 3) begin
            case (m_op)
                1: val = m_a + m_b;
                2: val = m_a - m_b;
                3: val = m_a * m_b;
                4: val = (m_b == 0) ? 0 : m_a / m_b;
                default: val = 0;
            endcase
            m_neg = (val < 0) ? 1 : 0;
            m_res = (val < 0) ? -val : val;
            m_vld = 1;
            m_ph  = 4;
        end else if (e_ != 0) begin
            case (m_ph)
                0: begin m_a = s_; m_err = 0; m_ph = 1; end
                1: begin
                    if (mode_legal(s_)) begin m_op = s_; m_err = 0; m_ph = 2; end
                    else m_err = 1;
                end
                2: begin
`ifdef CALC_DIV_EN
                    if (m_op == 4 && s_ == 0) m_err = 1;
                    else begin m_b = s_; m_err = 0; m_ph = 3; end
`else
                    m_b = s_; m_err = 0; m_ph = 3;
`endif
                end
                default: begin m_a = s_; m_vld = 0; m_ph = 1; end
            endcase
        end
    endtask

    vec_t vecs[$];

    initial begin
        rst = 1'b1; clear = 1'b0; enter = 1'b0; sw = 4'd0;

        //                rst clr ent sw  ph a  b  m  v  r   n  e
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0, 0, 0,  0, 0)); // reset state
        vecs.push_back(mk(0, 0, 1, 5,   1, 5, 0, 0, 0, 0,  0, 0)); // ADD: a=5
        vecs.push_back(mk(0, 0, 1, 1,   2, 5, 0, 1, 0, 0,  0, 0)); // op=ADD
        vecs.push_back(mk(0, 0, 1, 9,   3, 5, 9, 1, 0, 0,  0, 0)); // b=9, SETTLE, not valid yet
        vecs.push_back(mk(0, 0, 0, 0,   4, 5, 9, 1, 1, 14, 0, 0)); // valid two cycles after enter
        vecs.push_back(mk(0, 0, 1, 2,   1, 2, 9, 1, 0, 14, 0, 0)); // chaining from SHOW
        vecs.push_back(mk(0, 0, 1, 9,   1, 2, 9, 1, 0, 14, 0, 1)); // invalid op 9
        vecs.push_back(mk(0, 0, 0, 0,   1, 2, 9, 1, 0, 14, 0, 1)); // err holds while idle
        vecs.push_back(mk(0, 0, 1, 3,   2, 2, 9, 3, 0, 14, 0, 0)); // valid op clears err
        vecs.push_back(mk(0, 0, 1, 4,   3, 2, 4, 3, 0, 14, 0, 0)); // b=4
        vecs.push_back(mk(0, 0, 1, 7,   4, 2, 4, 3, 1, 8,  0, 0)); // enter in SETTLE ignored
        vecs.push_back(mk(0, 1, 0, 0,   0, 0, 0, 0, 0, 0,  0, 0)); // clear from SHOW
        vecs.push_back(mk(0, 0, 1, 3,   1, 3, 0, 0, 0, 0,  0, 0)); // SUB: a=3
        vecs.push_back(mk(0, 0, 1, 2,   2, 3, 0, 2, 0, 0,  0, 0));
        vecs.push_back(mk(0, 0, 1, 7,   3, 3, 7, 2, 0, 0,  0, 0));
        vecs.push_back(mk(0, 0, 0, 0,   4, 3, 7, 2, 1, 4,  1, 0)); // 3-7 = -4
        vecs.push_back(mk(0, 0, 1, 6,   1, 6, 7, 2, 0, 4,  1, 0));
        vecs.push_back(mk(0, 0, 1, 1,   2, 6, 7, 1, 0, 4,  1, 0));
        vecs.push_back(mk(0, 1, 1, 5,   0, 0, 0, 0, 0, 0,  0, 0)); // clear beats enter in GET_B
        vecs.push_back(mk(0, 0, 1, 8,   1, 8, 0, 0, 0, 0,  0, 0));
        vecs.push_back(mk(0, 0, 1, 3,   2, 8, 0, 3, 0, 0,  0, 0));
        vecs.push_back(mk(0, 0, 1, 2,   3, 8, 2, 3, 0, 0,  0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0, 0, 0,  0, 0)); // rst in SETTLE, no capture
        vecs.push_back(mk(0, 0, 1, 9,   1, 9, 0, 0, 0, 0,  0, 0));
`ifdef CALC_DIV_EN
        vecs.push_back(mk(0, 0, 1, 4,   2, 9, 0, 4, 0, 0,  0, 0)); // DIV accepted
        vecs.push_back(mk(0, 0, 1, 0,   2, 9, 0, 4, 0, 0,  0, 1)); // b=0 refused
        vecs.push_back(mk(0, 0, 1, 3,   3, 9, 3, 4, 0, 0,  0, 0));
        vecs.push_back(mk(0, 0, 0, 0,   4, 9, 3, 4, 1, 3,  0, 0)); // 9/3
        vecs.push_back(mk(0, 0, 0, 0,   4, 9, 3, 4, 1, 3,  0, 0)); // SHOW holds
`else
        vecs.push_back(mk(0, 0, 1, 4,   1, 9, 0, 0, 0, 0,  0, 1)); // DIV refused
        vecs.push_back(mk(0, 0, 1, 0,   1, 9, 0, 0, 0, 0,  0, 1)); // code 0 refused
        vecs.push_back(mk(0, 0, 1, 3,   2, 9, 0, 3, 0, 0,  0, 0));
        vecs.push_back(mk(0, 0, 1, 0,   3, 9, 0, 3, 0, 0,  0, 0)); // b=0 fine without divide
        vecs.push_back(mk(0, 0, 0, 0,   4, 9, 0, 3, 1, 0,  0, 0)); // 9*0
`endif

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].clr, vecs[i].ent, vecs[i].sw);
            check("table", i, vecs[i].ph, vecs[i].a, vecs[i].b, vecs[i].m,
                  vecs[i].v, vecs[i].r, vecs[i].n, vecs[i].e);
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            int r_, c_, e_, s_;
            r_ = (i == 0) ? 1 : (($urandom_range(0, 63) == 0) ? 1 : 0);
            c_ = ($urandom_range(0, 19) == 0) ? 1 : 0;
            e_ = ($urandom_range(0, 2) != 0) ? 1 : 0;
            s_ = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 15));
            drive(1'(r_), 1'(c_), 1'(e_), 4'(s_));
            model_step(r_, c_, e_, s_);
            check("random", i, 3'(m_ph), 4'(m_a), 4'(m_b), 4'(m_op),
                  1'(m_vld), 8'(m_res), 1'(m_neg), 1'(m_err));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
